hack_alu_pipe: RTL and testbench
================================

Name: hack_alu_pipe

Overview:
Parametrised, two-stage pipelined successor to the team's combinational Hack ALU. It uses the same six control bits (zx, nx, zy, ny, f, no) and adds valid/ready handshakes on both sides, full back-pressure, registered results, and status flags (zr, ng, carry, ovf). It sits between the CPU decode stage and writeback, so a stalled writeback never drops or duplicates an operation.

Parameters:
WIDTH, 16, operand and result width in bits (legal range 2 to 64).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand/control bundle is presented.
in_ready  output  1  block can accept the bundle this cycle.
x  input  WIDTH  operand X.
y  input  WIDTH  operand Y.
zx, nx, zy, ny, f, no  input  1 each  Hack control bits.
out_valid  output  1  result bundle is valid.
out_ready  input  1  consumer accepts the result this cycle.
out  output  WIDTH  result.
zr  output  1  out == 0.
ng  output  1  out[WIDTH-1].
carry  output  1  carry out of the WIDTH-bit add.
ovf  output  1  two's-complement overflow of the add.

Behaviour:
- Transfer rule: a transfer occurs on a rising edge where valid && ready. Accepted bundles complete in order; none are lost or duplicated.
- Stage 1 (S1): registers x', y', f, no and s1_valid.
  - x' = nx ? ~(zx ? 0 : x) : (zx ? 0 : x).
  - y' is formed the same way from zy, ny and y.
  - Zero is applied before negation (Hack semantics).
- Stage 2 (S2): registers out, the flags and out_valid.
  - r = f ? (x' + y') mod 2^WIDTH : (x' & y').
  - out = no ? ~r : r.
  - carry = f ? bit WIDTH of the (WIDTH+1)-bit sum : 0.
  - ovf = f ? (x'[MSB] == y'[MSB]) && (sum[MSB] != x'[MSB]) : 0.
  - carry and ovf are taken from the raw sum, before "no".
  - zr and ng are computed from the final out.
- Advance conditions:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. in_ready is combinational from out_ready; there is no path from in_valid to in_ready.
- Latency: 2 cycles from acceptance to out_valid when not stalled. Throughput is 1 op/cycle.
- Stall: while out_valid && !out_ready, S2 holds out and all flags stable.
  - S1 may still fill if it is empty.
  - Once both stages are full, in_ready = 0.
  - Capacity is 2 ops.
- Simultaneous events: when out_valid && out_ready && s1_valid on the same edge, S2 loads from S1 and S1 loads a new input if one is presented; there is no bubble.
- Reset: on a rising edge with rst = 1:
  - s1_valid and out_valid are cleared to 0.
  - out, zr, ng, carry and ovf are cleared to 0.
  - in_ready reads 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight ops; none emerge afterwards.
  - Inputs are ignored while rst = 1.
- Data registers load only when their stage advances with valid data.
- Outputs are don't-care when out_valid = 0, but the bench checks the reset values.

Test Plan:
1. WIDTH=16, the result "0" (zx=1, nx=0, zy=1, ny=0, f=1, no=0) with x=0x1234, y=0x5678 -> 2 cycles later out=0x0000, zr=1, ng=0, carry=0.
2. "x+1" (0,1,1,1,1,1) with x=5 -> out=0x0006. Then "x-y" (0,1,0,0,1,1) with x=3, y=5 -> out=0xFFFE, ng=1, zr=0.
3. x=0xFFFF, y=0x0001, add (0,0,0,0,1,0) -> out=0x0000, zr=1, carry=1, ovf=0. Then x=0x7FFF, y=0x0001 -> out=0x8000, ng=1, ovf=1, carry=0.
4. Back-pressure: hold out_ready=0 and present ops A, B, C on consecutive cycles.
   - A and B are accepted; in_ready=0 while C is held.
   - out stays at A's value throughout.
   - Raising out_ready yields A, B, C in order, one per cycle, with no repeats.
5. Streaming: 100 random ops with in_valid=1 and out_ready=1 -> one result per cycle after 2-cycle latency, matching the reference model bit-exactly including flags. Repeat with random out_ready toggling.
6. Assert rst for one cycle while both stages are full -> next cycle out_valid=0, out=0, all flags 0, in_ready=1, and no stale result ever appears. Also run WIDTH=8 with x=0x7F, y=0x01 add -> out=0x80, ovf=1.

Source files
------------

// File: rtl/hack_alu_pipe.sv
// Two-stage pipelined Hack ALU with zr/ng/carry/ovf flags; latency 2, one op per cycle.
// Back-pressure holds S2 stable, S1 still fills; in_ready drops only with both stages full.
module hack_alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             carry,
  output logic             ovf
);

  typedef struct packed {
    logic [WIDTH-1:0] xp;
    logic [WIDTH-1:0] yp;
    logic             f;
    logic             no;
  } s1_t;

  s1_t  s1_q;
  s1_t  s1_d;
  logic s1_valid;
  logic s1_adv;
  logic s2_adv;

  logic [WIDTH-1:0] x_zero;
  logic [WIDTH-1:0] y_zero;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] res;
  logic             res_carry;
  logic             res_ovf;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Zero before negate, matching the original combinational Hack ALU.
  always_comb begin
    x_zero  = zx ? '0 : x;
    y_zero  = zy ? '0 : y;
    s1_d.xp = nx ? ~x_zero : x_zero;
    s1_d.yp = ny ? ~y_zero : y_zero;
    s1_d.f  = f;
    s1_d.no = no;
  end

  // Carry and overflow describe the raw add, not the post-"no" result.
  always_comb begin
    sum       = {1'b0, s1_q.xp} + {1'b0, s1_q.yp};
    r         = s1_q.f ? sum[WIDTH-1:0] : (s1_q.xp & s1_q.yp);
    res       = s1_q.no ? ~r : r;
    res_carry = s1_q.f && sum[WIDTH];
    res_ovf   = s1_q.f && (s1_q.xp[WIDTH-1] == s1_q.yp[WIDTH-1]) &&
                (sum[WIDTH-1] != s1_q.xp[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (s1_adv && in_valid) begin
        s1_q <= s1_d;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
      end
      if (s2_adv && s1_valid) begin
        out   <= res;
        zr    <= (res == '0);
        ng    <= res[WIDTH-1];
        carry <= res_carry;
        ovf   <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Self-checking bench for hack_alu_pipe: table vectors, back-pressure, streaming, reset flush, 8-bit corner.
module tb_hack_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] x, y;
  logic        zx, nx, zy, ny, f, no;
  logic        out_valid, out_ready;
  logic [15:0] out;
  logic        zr, ng, carry, ovf;

  logic        rdy_manual, rand_rdy, rnd_bit;
  assign out_ready = rand_rdy ? rnd_bit : rdy_manual;

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] x8, y8, out8;
  logic       zr8, ng8, carry8, ovf8;

  hack_alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zr(zr), .ng(ng), .carry(carry), .ovf(ovf)
  );

  hack_alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .y(y8), .zx(1'b0), .nx(1'b0), .zy(1'b0), .ny(1'b0), .f(1'b1), .no(1'b0),
    .out_valid(out_valid8), .out_ready(out_ready8), .out(out8),
    .zr(zr8), .ng(ng8), .carry(carry8), .ovf(ovf8)
  );

  typedef struct packed {
    logic [15:0] out;
    logic        zr;
    logic        ng;
    logic        carry;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  c;  // {zx,nx,zy,ny,f,no}
    res_t        e;
  } vec_t;

  res_t exp_q[$];
  res_t mon_got, mon_exp;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  function automatic res_t model(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] c);
    logic [15:0] xp, yp, r;
    int unsigned s;
    res_t e;
    xp = c[5] ? 16'h0000 : xv;
    if (c[4]) xp = ~xp;
    yp = c[3] ? 16'h0000 : yv;
    if (c[2]) yp = ~yp;
    s = int'(xp) + int'(yp);
    r = c[1] ? s[15:0] : (xp & yp);
    if (c[0]) r = ~r;
    e.out   = r;
    e.zr    = (r == 16'h0000);
    e.ng    = r[15];
    e.carry = c[1] && (s > 32'hFFFF);
    e.ovf   = c[1] && (xp[15] == yp[15]) && (s[15] != xp[15]);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Output scoreboard: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_got = {out, zr, ng, carry, ovf};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %0h with nothing outstanding", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL result: got out=%h zr=%b ng=%b c=%b v=%b expected out=%h zr=%b ng=%b c=%b v=%b",
                   mon_got.out, mon_got.zr, mon_got.ng, mon_got.carry, mon_got.ovf,
                   mon_exp.out, mon_exp.zr, mon_exp.ng, mon_exp.carry, mon_exp.ovf);
        end
      end
    end
  end

  task automatic send(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] c, input res_t e);
    bit ok;
    x = xv;
    y = yv;
    {zx, nx, zy, ny, f, no} = c;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (ok) begin
      exp_q.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t vecs[9];
  res_t ea, eb, ec;
  int   t0;
  bit   got8;

  initial begin
    vecs[0] = '{16'h1234, 16'h5678, 6'b101010, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{16'h0005, 16'h0000, 6'b011111, '{16'h0006, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[2] = '{16'h0003, 16'h0005, 6'b010011, '{16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0}};
    vecs[3] = '{16'hFFFF, 16'h0001, 6'b000010, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[4] = '{16'h7FFF, 16'h0001, 6'b000010, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[5] = '{16'hF0F0, 16'h3C3C, 6'b000000, '{16'h3030, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[6] = '{16'hF0F0, 16'h0F00, 6'b010101, '{16'hFFF0, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[7] = '{16'hABCD, 16'h1234, 6'b111010, '{16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[8] = '{16'h8000, 16'h8000, 6'b000010, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b1}};

    rst = 1'b1;
    in_valid = 1'b0;
    x = '0; y = '0;
    {zx, nx, zy, ny, f, no} = '0;
    rdy_manual = 1'b1;
    rand_rdy = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; x8 = '0; y8 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out", 64'(out), 64'd0);
    check("reset_flags", 64'({zr, ng, carry, ovf}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) send(vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].e);
    drain();

    // Back-pressure: A and B fill both stages, C must wait.
    ea = model(16'h1111, 16'h2222, 6'b000010);
    eb = model(16'h0003, 16'h0005, 6'b010011);
    ec = model(16'h00FF, 16'h0F0F, 6'b000000);
    rdy_manual = 1'b0;
    send(16'h1111, 16'h2222, 6'b000010, ea);
    send(16'h0003, 16'h0005, 6'b010011, eb);
    x = 16'h00FF; y = 16'h0F0F; {zx, nx, zy, ny, f, no} = 6'b000000;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_hold", 64'(out), 64'(ea.out));
    end
    @(posedge clk);
    #1;
    rdy_manual = 1'b1;
    send(16'h00FF, 16'h0F0F, 6'b000000, ec);
    drain();

    // Full-rate streaming: one acceptance per cycle.
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      logic [15:0] rx, ry;
      logic [5:0]  rc;
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 6'($urandom);
      send(rx, ry, rc, model(rx, ry, rc));
    end
    check("stream_cycles", 64'(cyc - t0), 64'd100);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic [15:0] rx, ry;
      logic [5:0]  rc;
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 6'($urandom);
      send(rx, ry, rc, model(rx, ry, rc));
    end
    rand_rdy = 1'b0;
    drain();

    // Reset with both stages full; nothing in flight may emerge afterwards.
    rdy_manual = 1'b0;
    send(16'h0001, 16'h0002, 6'b000010, model(16'h0001, 16'h0002, 6'b000010));
    send(16'h0004, 16'h0008, 6'b000010, model(16'h0004, 16'h0008, 6'b000010));
    rst = 1'b1;
    x = 16'h7FFF; y = 16'h0001; {zx, nx, zy, ny, f, no} = 6'b000010;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out", 64'(out), 64'd0);
    check("flush_flags", 64'({zr, ng, carry, ovf}), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    rdy_manual = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("flush_no_stale", 64'(out_valid), 64'd0);
    end

    // WIDTH=8 signed-overflow corner.
    @(posedge clk);
    #1;
    x8 = 8'h7F; y8 = 8'h01; in_valid8 = 1'b1; out_ready8 = 1'b1;
    got8 = 1'b0;
    for (int i = 0; i < 20 && !got8; i++) begin
      @(negedge clk);
      if (in_ready8) got8 = 1'b1;
    end
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    got8 = 1'b0;
    for (int i = 0; i < 20 && !got8; i++) begin
      @(negedge clk);
      if (out_valid8) got8 = 1'b1;
    end
    check("w8_out_valid", 64'(got8), 64'd1);
    check("w8_out", 64'(out8), 64'h80);
    check("w8_flags", 64'({zr8, ng8, carry8, ovf8}), 64'b0101);

    @(posedge clk);
    #1;
    check("final_outstanding", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
